// File: rtl/decode_stage_pipelined_pkg.sv
// ============================================================================
// Module : decode_pkg
// Brief  : Shared encodings for the decode stage (branch compare modes, PC select).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    typedef enum logic [1:0] {
        BR_EQ  = 2'b00,
        BR_NE  = 2'b01,
        BR_LEZ = 2'b10,
        BR_GTZ = 2'b11
    } br_mode_e;

    typedef enum logic [1:0] {
        PCSEL_BRANCH = 2'b00,
        PCSEL_JR     = 2'b01,
        PCSEL_JUMP   = 2'b10,
        PCSEL_PC4    = 2'b11
    } pc_sel_e;

endpackage

`default_nettype wire

// File: rtl/decode_stage_pipelined_if.sv
// ============================================================================
// Module : decode_stage_pipelined_if
// Brief  : Bundles the decode-stage inputs and ID/EX outputs; slave = the stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface decode_stage_pipelined_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int RF_ADDR_WIDTH = 5
);
    logic [INSTR_WIDTH-1:0]   i_InstrD;
    logic [ADDRESS_WIDTH-1:0] i_PCPlus4D;
    logic [RF_ADDR_WIDTH-1:0] i_WriteRegW;
    logic                     i_RegWriteW;
    logic [DATA_WIDTH-1:0]    i_ResultW;
    logic [DATA_WIDTH-1:0]    i_ALUOutM;
    logic                     i_ForwardAD;
    logic                     i_ForwardBD;
    logic                     i_BranchD;
    logic [1:0]               i_BrModeD;
    logic [1:0]               i_PC_SELD;
    logic                     i_StallD;
    logic                     i_FlushE;
    logic [ADDRESS_WIDTH-1:0] o_PCNextD;
    logic                     o_BranchTakenD;
    logic [DATA_WIDTH-1:0]    o_SrcAE;
    logic [DATA_WIDTH-1:0]    o_SrcBE;
    logic [DATA_WIDTH-1:0]    o_SignImmE;
    logic [RF_ADDR_WIDTH-1:0] o_RsE;
    logic [RF_ADDR_WIDTH-1:0] o_RtE;
    logic [RF_ADDR_WIDTH-1:0] o_RdE;
    logic                     o_ValidE;

    modport slave (
        input  i_InstrD, i_PCPlus4D, i_WriteRegW, i_RegWriteW, i_ResultW, i_ALUOutM,
               i_ForwardAD, i_ForwardBD, i_BranchD, i_BrModeD, i_PC_SELD, i_StallD, i_FlushE,
        output o_PCNextD, o_BranchTakenD, o_SrcAE, o_SrcBE, o_SignImmE,
               o_RsE, o_RtE, o_RdE, o_ValidE
    );

    modport master (
        output i_InstrD, i_PCPlus4D, i_WriteRegW, i_RegWriteW, i_ResultW, i_ALUOutM,
               i_ForwardAD, i_ForwardBD, i_BranchD, i_BrModeD, i_PC_SELD, i_StallD, i_FlushE,
        input  o_PCNextD, o_BranchTakenD, o_SrcAE, o_SrcBE, o_SignImmE,
               o_RsE, o_RtE, o_RdE, o_ValidE
    );

endinterface

`default_nettype wire

// File: rtl/decode_stage_pipelined_reg_file_bypass.sv
// ============================================================================
// Module : reg_file_bypass
// Brief  : 2R/1W register file, r0 hardwired to zero, write-first read bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_bypass #(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     we_i,
    input  logic [RF_ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [RF_ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0]    rdata_a_o,
    input  logic [RF_ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0]    rdata_b_o
);
    localparam int NREGS = 2 ** RF_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic                  w_wr_en;

    assign w_wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle writeback is visible to the reader (write-first).
    assign rdata_a_o = (raddr_a_i == '0)                  ? '0      :
                       (w_wr_en && raddr_a_i == waddr_i)  ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0)                  ? '0      :
                       (w_wr_en && raddr_b_i == waddr_i)  ? wdata_i : regs_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/decode_stage_pipelined.sv
// ============================================================================
// Module : decode_stage_pipelined
// Brief  : MIPS decode stage: RF read, sign-extend, ID branch resolve, next-PC, ID/EX reg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_stage_pipelined
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH     = 16
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    decode_stage_pipelined_if.slave bus
);
    typedef struct packed {
        logic                     valid;
        logic [DATA_WIDTH-1:0]    src_a;
        logic [DATA_WIDTH-1:0]    src_b;
        logic [DATA_WIDTH-1:0]    sign_imm;
        logic [RF_ADDR_WIDTH-1:0] rs;
        logic [RF_ADDR_WIDTH-1:0] rt;
        logic [RF_ADDR_WIDTH-1:0] rd;
    } idex_t;

    logic [RF_ADDR_WIDTH-1:0] w_rs, w_rt, w_rd;
    logic [DATA_WIDTH-1:0]    w_rd_a, w_rd_b;
    logic [IMM_WIDTH-1:0]     w_imm_field;
    logic [DATA_WIDTH-1:0]    w_sign_imm;
    logic [ADDRESS_WIDTH-1:0] w_br_tgt, w_jump_tgt;
    logic [DATA_WIDTH-1:0]    w_cmp_a, w_cmp_b;
    logic                     w_cond;
    logic                     w_unused_instr;
    idex_t                    idex_d, idex_q;

    assign w_rs        = bus.i_InstrD[21 +: RF_ADDR_WIDTH];
    assign w_rt        = bus.i_InstrD[16 +: RF_ADDR_WIDTH];
    assign w_rd        = bus.i_InstrD[11 +: RF_ADDR_WIDTH];
    assign w_imm_field = bus.i_InstrD[IMM_WIDTH-1:0];
    assign w_unused_instr = ^bus.i_InstrD[INSTR_WIDTH-1:26];

    reg_file_bypass #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RF_ADDR_WIDTH(RF_ADDR_WIDTH)
    ) u_rf (
        .clk_i    (i_CLK),
        .rst_n_i  (i_RST),
        .we_i     (bus.i_RegWriteW),
        .waddr_i  (bus.i_WriteRegW),
        .wdata_i  (bus.i_ResultW),
        .raddr_a_i(w_rs),
        .rdata_a_o(w_rd_a),
        .raddr_b_i(w_rt),
        .rdata_b_o(w_rd_b)
    );

    assign w_sign_imm = DATA_WIDTH'($signed(w_imm_field));
    assign w_br_tgt   = bus.i_PCPlus4D + (ADDRESS_WIDTH'($signed(w_imm_field)) << 2);

    // A 28-bit PC has no region bits to carry over from PC+4.
    if (ADDRESS_WIDTH > 28) begin : g_jump_region
        assign w_jump_tgt = {bus.i_PCPlus4D[ADDRESS_WIDTH-1:28], bus.i_InstrD[25:0], 2'b00};
    end else begin : g_jump_flat
        assign w_jump_tgt = {bus.i_InstrD[25:0], 2'b00};
    end

    assign w_cmp_a = bus.i_ForwardAD ? bus.i_ALUOutM : w_rd_a;
    assign w_cmp_b = bus.i_ForwardBD ? bus.i_ALUOutM : w_rd_b;

    always_comb begin
        w_cond = 1'b0;
        case (bus.i_BrModeD)
            BR_EQ:   w_cond = (w_cmp_a == w_cmp_b);
            BR_NE:   w_cond = (w_cmp_a != w_cmp_b);
            BR_LEZ:  w_cond = w_cmp_a[DATA_WIDTH-1] || (w_cmp_a == '0);
            BR_GTZ:  w_cond = !w_cmp_a[DATA_WIDTH-1] && (w_cmp_a != '0);
            default: w_cond = 1'b0;
        endcase
    end

    assign bus.o_BranchTakenD = bus.i_BranchD && w_cond;

    always_comb begin
        bus.o_PCNextD = bus.i_PCPlus4D;
        case (bus.i_PC_SELD)
            PCSEL_BRANCH: bus.o_PCNextD = w_br_tgt;
            PCSEL_JR:     bus.o_PCNextD = ADDRESS_WIDTH'(w_cmp_a);
            PCSEL_JUMP:   bus.o_PCNextD = w_jump_tgt;
            default:      bus.o_PCNextD = bus.i_PCPlus4D;
        endcase
    end

    // Flush outranks stall so a squashed slot never survives a held pipeline.
    always_comb begin
        idex_d = idex_q;
        if (bus.i_FlushE) begin
            idex_d = '0;
        end else if (!bus.i_StallD) begin
            idex_d.valid    = 1'b1;
            idex_d.src_a    = w_rd_a;
            idex_d.src_b    = w_rd_b;
            idex_d.sign_imm = w_sign_imm;
            idex_d.rs       = w_rs;
            idex_d.rt       = w_rt;
            idex_d.rd       = w_rd;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.o_ValidE   = idex_q.valid;
    assign bus.o_SrcAE    = idex_q.src_a;
    assign bus.o_SrcBE    = idex_q.src_b;
    assign bus.o_SignImmE = idex_q.sign_imm;
    assign bus.o_RsE      = idex_q.rs;
    assign bus.o_RtE      = idex_q.rt;
    assign bus.o_RdE      = idex_q.rd;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipelined.sv
// ============================================================================
// Module : tb_decode_stage_pipelined
// Brief  : Directed bench; ID/EX results checked by a scoreboard monitor, comb outputs inline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_pipelined;

    typedef struct packed {
        logic        chk;
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sbq[$];

    decode_stage_pipelined_if bus ();

    decode_stage_pipelined dut (
        .i_CLK(clk),
        .i_RST(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd);
        exp_t e;
        e.chk = 1'b1; e.v = v; e.a = a; e.b = b; e.imm = imm; e.rs = rs; e.rt = rt; e.rd = rd;
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {6'h00, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step(input exp_t e);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor: one entry per clock edge, compared after the edge settles.
    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {1'b1, bus.o_ValidE, bus.o_SrcAE, bus.o_SrcBE, bus.o_SignImmE,
                 bus.o_RsE, bus.o_RtE, bus.o_RdE};
            if (e.chk) begin
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL idex@%0t: got v=%b a=%h b=%h imm=%h rs=%0d rt=%0d rd=%0d expected v=%b a=%h b=%h imm=%h rs=%0d rt=%0d rd=%0d",
                             $time, a.v, a.a, a.b, a.imm, a.rs, a.rt, a.rd,
                             e.v, e.a, e.b, e.imm, e.rs, e.rt, e.rd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t z;
        exp_t ea;
        z = ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        rst_n           = 1'b0;
        bus.i_InstrD    = mk(5'd5, 5'd0, 16'h0);
        bus.i_PCPlus4D  = 32'h0040_0010;
        bus.i_WriteRegW = 5'd0;
        bus.i_RegWriteW = 1'b0;
        bus.i_ResultW   = 32'h0;
        bus.i_ALUOutM   = 32'h0;
        bus.i_ForwardAD = 1'b0;
        bus.i_ForwardBD = 1'b0;
        bus.i_BranchD   = 1'b0;
        bus.i_BrModeD   = 2'b00;
        bus.i_PC_SELD   = 2'b11;
        bus.i_StallD    = 1'b0;
        bus.i_FlushE    = 1'b0;

        @(negedge clk);
        #1;
        chk("reset_valid", {31'd0, bus.o_ValidE}, 32'd0);
        chk("reset_srca", bus.o_SrcAE, 32'd0);
        step(z);
        rst_n = 1'b1;

        // write r5 with a same-cycle JR read of r5
        bus.i_RegWriteW = 1'b1; bus.i_WriteRegW = 5'd5; bus.i_ResultW = 32'hAAAA_5555;
        bus.i_PC_SELD   = 2'b01;
        #1 chk("jr_bypass_r5", bus.o_PCNextD, 32'hAAAA_5555);
        step(ex(1'b1, 32'hAAAA_5555, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0));
        bus.i_RegWriteW = 1'b0;
        #1 chk("jr_array_r5", bus.o_PCNextD, 32'hAAAA_5555);
        step(ex(1'b1, 32'hAAAA_5555, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0));

        // asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.o_ValidE}, 32'd0);
        chk("async_rst_srca", bus.o_SrcAE, 32'd0);
        chk("async_rst_r5", bus.o_PCNextD, 32'd0);
        step(z);
        rst_n = 1'b1;
        #1 chk("post_rst_r5", bus.o_PCNextD, 32'd0);
        step(ex(1'b1, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0));

        // write-first bypass into E, and r0 stays zero
        bus.i_RegWriteW = 1'b1; bus.i_WriteRegW = 5'd3; bus.i_ResultW = 32'h0000_1234;
        bus.i_InstrD    = mk(5'd3, 5'd0, 16'h0);
        step(ex(1'b1, 32'h1234, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0));
        bus.i_WriteRegW = 5'd0; bus.i_ResultW = 32'h0000_FFFF;
        bus.i_InstrD    = mk(5'd0, 5'd3, 16'h0);
        #1 chk("r0_write_bypass", bus.o_PCNextD, 32'd0);
        step(ex(1'b1, 32'h0, 32'h1234, 32'h0, 5'd0, 5'd3, 5'd0));
        bus.i_RegWriteW = 1'b0;
        bus.i_InstrD    = mk(5'd0, 5'd0, 16'h0);
        #1 chk("r0_after_write", bus.o_PCNextD, 32'd0);
        step(ex(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0));

        // branch modes with A = B = 0xFFFFFFFF (r1 written this cycle)
        bus.i_PC_SELD   = 2'b11;
        bus.i_RegWriteW = 1'b1; bus.i_WriteRegW = 5'd1; bus.i_ResultW = 32'hFFFF_FFFF;
        bus.i_InstrD    = mk(5'd1, 5'd1, 16'h0);
        bus.i_BranchD   = 1'b1;
        bus.i_BrModeD = 2'b00; #1 chk("br_eq_neg1", {31'd0, bus.o_BranchTakenD}, 32'd1);
        bus.i_BrModeD = 2'b01; #1 chk("br_ne_neg1", {31'd0, bus.o_BranchTakenD}, 32'd0);
        bus.i_BrModeD = 2'b10; #1 chk("br_lez_neg1", {31'd0, bus.o_BranchTakenD}, 32'd1);
        bus.i_BrModeD = 2'b11; #1 chk("br_gtz_neg1", {31'd0, bus.o_BranchTakenD}, 32'd0);
        step(ex(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd1, 5'd1, 5'd0));

        // A = 1 (r2), B = 0xFFFFFFFF
        bus.i_WriteRegW = 5'd2; bus.i_ResultW = 32'h1;
        bus.i_InstrD    = mk(5'd2, 5'd1, 16'h0);
        bus.i_BrModeD = 2'b11; #1 chk("br_gtz_one", {31'd0, bus.o_BranchTakenD}, 32'd1);
        bus.i_BrModeD = 2'b10; #1 chk("br_lez_one", {31'd0, bus.o_BranchTakenD}, 32'd0);
        bus.i_BrModeD = 2'b01; #1 chk("br_ne_one", {31'd0, bus.o_BranchTakenD}, 32'd1);
        bus.i_BranchD = 1'b0; bus.i_BrModeD = 2'b11;
        #1 chk("br_not_branch", {31'd0, bus.o_BranchTakenD}, 32'd0);
        step(ex(1'b1, 32'h1, 32'hFFFF_FFFF, 32'h0, 5'd2, 5'd1, 5'd0));

        // forwarding of operand A from the memory stage
        bus.i_WriteRegW = 5'd7; bus.i_ResultW = 32'h7;
        bus.i_InstrD    = mk(5'd1, 5'd7, 16'h0);
        bus.i_BranchD   = 1'b1; bus.i_BrModeD = 2'b00; bus.i_ALUOutM = 32'h7;
        #1 chk("br_eq_nofwd", {31'd0, bus.o_BranchTakenD}, 32'd0);
        bus.i_ForwardAD = 1'b1;
        #1 chk("br_eq_fwda", {31'd0, bus.o_BranchTakenD}, 32'd1);
        step(ex(1'b1, 32'hFFFF_FFFF, 32'h7, 32'h0, 5'd1, 5'd7, 5'd0));
        bus.i_ForwardAD = 1'b0; bus.i_BranchD = 1'b0; bus.i_RegWriteW = 1'b0;

        // next-PC selection
        bus.i_PCPlus4D = 32'h0040_0010;
        bus.i_InstrD   = mk(5'd0, 5'd0, 16'hFFFF);
        bus.i_PC_SELD  = 2'b00;
        #1 chk("pc_branch_back", bus.o_PCNextD, 32'h0040_000C);
        step(ex(1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd31));
        bus.i_InstrD   = {6'h02, 26'h010_0000};
        bus.i_PC_SELD  = 2'b10;
        #1 chk("pc_jump", bus.o_PCNextD, 32'h0040_0000);
        bus.i_PCPlus4D = 32'hF000_0004;
        #1 chk("pc_jump_region", bus.o_PCNextD, 32'hF040_0000);
        bus.i_PC_SELD  = 2'b11;
        #1 chk("pc_plus4", bus.o_PCNextD, 32'hF000_0004);
        step(ex(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd16, 5'd0));
        bus.i_PCPlus4D = 32'h0000_0004;
        bus.i_InstrD   = mk(5'd0, 5'd0, 16'hFFFE);
        bus.i_PC_SELD  = 2'b00;
        #1 chk("pc_branch_wrap", bus.o_PCNextD, 32'hFFFF_FFFC);
        step(ex(1'b1, 32'h0, 32'h0, 32'hFFFF_FFFE, 5'd0, 5'd0, 5'd31));
        bus.i_PC_SELD  = 2'b11;

        // stall / flush behaviour of the ID/EX register
        ea = ex(1'b1, 32'h1234, 32'hFFFF_FFFF, 32'h8, 5'd3, 5'd1, 5'd0);
        bus.i_InstrD = mk(5'd3, 5'd1, 16'h0008);
        step(ea);
        bus.i_StallD = 1'b1;
        bus.i_InstrD = mk(5'd2, 5'd7, 16'h0010);
        step(ea);
        bus.i_RegWriteW = 1'b1; bus.i_WriteRegW = 5'd2; bus.i_ResultW = 32'h55;
        step(ea);
        bus.i_RegWriteW = 1'b0;
        bus.i_FlushE    = 1'b1;
        step(z);
        bus.i_StallD = 1'b0; bus.i_FlushE = 1'b0;
        step(ex(1'b1, 32'h55, 32'h7, 32'h10, 5'd2, 5'd7, 5'd0));
        bus.i_FlushE = 1'b1;
        step(z);
        bus.i_FlushE = 1'b0;
        bus.i_InstrD = mk(5'd7, 5'd2, 16'h8000);
        step(ex(1'b1, 32'h7, 32'h55, 32'hFFFF_8000, 5'd7, 5'd2, 5'd16));

        repeat (2) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
